// File: rtl/nco_pkg.sv
// Shared constants, enums and note increments for the NCO voice generator
// and its upstream tone calculator.
package nco_pkg;

  localparam int INC_W      = 32;
  localparam int IDX_W      = 5;
  localparam int SAMPLE_W   = 16;
  localparam int GAIN_W     = 6;
  localparam int GAIN_MAX   = 32;
  localparam int GAIN_SHIFT = $clog2(GAIN_MAX);
  localparam int PROD_W     = SAMPLE_W + GAIN_W + 1;

  localparam logic [GAIN_W-1:0] GAIN_FULL = GAIN_W'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] GAIN_ONE  = GAIN_W'(1);

  typedef enum logic [1:0] {
    WAVE_SQUARE,
    WAVE_SAW,
    WAVE_TRI,
    WAVE_SINE
  } wave_sel_e;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    SUSTAIN,
    RELEASE
  } voice_state_e;

  // Q5.27 increments at 48 kHz with a 32-entry table.
  localparam logic [INC_W-1:0] NOTE_A4_INC = 32'h0258_BF00;
  localparam logic [INC_W-1:0] NOTE_A5_INC = 32'h04B1_7E00;

  // First quadrant (k = 0..8) of round(32767*sin(2*pi*k/32)); the rest is mirrored.
  function automatic logic signed [SAMPLE_W-1:0] sine_lookup(input logic [IDX_W-1:0] k);
    logic [3:0]                 m;
    logic signed [SAMPLE_W-1:0] q;
    m = k[3] ? 4'(5'd16 - {1'b0, k[3:0]}) : k[3:0];
    case (m)
      4'd0:    q = 16'sd0;
      4'd1:    q = 16'sd6393;
      4'd2:    q = 16'sd12539;
      4'd3:    q = 16'sd18204;
      4'd4:    q = 16'sd23170;
      4'd5:    q = 16'sd27245;
      4'd6:    q = 16'sd30273;
      4'd7:    q = 16'sd32137;
      default: q = 16'sd32767;
    endcase
    return k[4] ? -q : q;
  endfunction

endpackage

// File: rtl/nco_wave_rom.sv
// Combinational 32-entry waveform lookup: (wave select, phase index) -> signed sample.
module nco_wave_rom
  import nco_pkg::*;
(
  input  wave_sel_e                  wave_sel_i,
  input  logic [IDX_W-1:0]           idx_i,
  output logic signed [SAMPLE_W-1:0] sample_o
);

  logic signed [31:0] k_s;
  assign k_s = $signed({{(32-IDX_W){1'b0}}, idx_i});

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    sample_o = '0;
    unique case (wave_sel_i)
      WAVE_SQUARE: sample_o = idx_i[IDX_W-1] ? 16'sh8000 : 16'sh7FFF;
      WAVE_SAW:    sample_o = SAMPLE_W'(-32768 + 2048 * k_s);
      WAVE_TRI:    sample_o = idx_i[IDX_W-1] ? SAMPLE_W'(32767 - 4096 * (k_s - 16))
                                             : SAMPLE_W'(-32768 + 4096 * k_s);
      WAVE_SINE:   sample_o = sine_lookup(idx_i);
    endcase
  end

endmodule

// File: rtl/nco_voice_generator.sv
// Phase-accumulator voice: advances on each sample tick, looks up a waveform and
// applies a linear attack/release gain ramp; one sample_valid per tick, 2 cycles later.
module nco_voice_generator
  import nco_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_tick,
  input  logic [INC_W-1:0]           nco_increment_value,
  input  logic                       nco_mute,
  input  logic [1:0]                 wave_sel,
  output logic signed [SAMPLE_W-1:0] sample_data,
  output logic                       sample_valid,
  output logic                       voice_active
);

  logic [INC_W-1:0]  acc_q, acc_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  voice_state_e      state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  wave_sel_e         wave_q;
  logic              s1_valid_q;

  logic [GAIN_W-1:0] gain_up, gain_down;
  assign gain_up   = (gain_q >= GAIN_FULL) ? GAIN_FULL : gain_q + GAIN_ONE;
  assign gain_down = (gain_q == '0) ? '0 : gain_q - GAIN_ONE;

  always_comb begin
    acc_d   = acc_q + nco_increment_value;
    gain_d  = gain_q;
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!nco_mute) begin
          state_d = ATTACK;
          gain_d  = GAIN_ONE;
        end else begin
          acc_d  = '0;
          gain_d = '0;
        end
      end
      ATTACK: begin
        if (nco_mute) begin
          state_d = RELEASE;
          gain_d  = gain_down;
        end else begin
          gain_d = gain_up;
          if (gain_up == GAIN_FULL) state_d = SUSTAIN;
        end
      end
      SUSTAIN: begin
        if (nco_mute) begin
          state_d = RELEASE;
          gain_d  = GAIN_FULL - GAIN_ONE;
        end
      end
      RELEASE: begin
        if (!nco_mute) begin
          state_d = ATTACK;
          gain_d  = gain_up;
        end else begin
          gain_d = gain_down;
          if (gain_down == '0) begin
            state_d = IDLE;
            acc_d   = '0;
          end
        end
      end
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      gain_q     <= '0;
      state_q    <= IDLE;
      idx_q      <= '0;
      wave_q     <= WAVE_SQUARE;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= sample_tick;
      if (sample_tick) begin
        acc_q   <= acc_d;
        gain_q  <= gain_d;
        state_q <= state_d;
        idx_q   <= acc_d[INC_W-1 -: IDX_W];
        wave_q  <= wave_sel_e'(wave_sel);
      end
    end
  end

  logic signed [SAMPLE_W-1:0] rom_sample;

  nco_wave_rom u_wave_rom (
    .wave_sel_i (wave_q),
    .idx_i      (idx_q),
    .sample_o   (rom_sample)
  );

  // Gain is unsigned, so it gets a zero sign bit before the signed multiply.
  logic signed [PROD_W-1:0] prod;
  assign prod = PROD_W'(rom_sample) * PROD_W'($signed({1'b0, gain_q}));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= s1_valid_q;
      if (s1_valid_q) sample_data <= SAMPLE_W'(prod >>> GAIN_SHIFT);
    end
  end

  assign voice_active = (state_q != IDLE);

endmodule

// File: tb/tb_nco_voice_generator.sv
// Directed bench for nco_voice_generator: ramp, wrap, release, re-attack, async reset.
module tb_nco_voice_generator;
  import nco_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       sample_tick;
  logic [INC_W-1:0]           nco_increment_value;
  logic                       nco_mute;
  logic [1:0]                 wave_sel;
  logic signed [SAMPLE_W-1:0] sample_data;
  logic                       sample_valid;
  logic                       voice_active;

  int n_cmp = 0;
  int n_err = 0;

  int sine_tab [32] = '{0, 6393, 12539, 18204, 23170, 27245, 30273, 32137,
                        32767, 32137, 30273, 27245, 23170, 18204, 12539, 6393,
                        0, -6393, -12539, -18204, -23170, -27245, -30273, -32137,
                        -32767, -32137, -30273, -27245, -23170, -18204, -12539, -6393};

  nco_voice_generator dut (
    .clk                 (clk),
    .rst                 (rst),
    .sample_tick         (sample_tick),
    .nco_increment_value (nco_increment_value),
    .nco_mute            (nco_mute),
    .wave_sel            (wave_sel),
    .sample_data         (sample_data),
    .sample_valid        (sample_valid),
    .voice_active        (voice_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int wave_model(input int sel, input int k);
    case (sel)
      0:       return (k < 16) ? 32767 : -32768;
      1:       return -32768 + 2048 * k;
      2:       return (k < 16) ? (-32768 + 4096 * k) : (32767 - 4096 * (k - 16));
      default: return sine_tab[k];
    endcase
  endfunction

  function automatic int exp_sample(input int sel, input int k, input int g);
    int p;
    p = wave_model(sel, k) * g;
    return p >>> 5;
  endfunction

  // Called at a negedge: one-cycle tick, checks the valid arrives exactly 2 edges later.
  task automatic tick(input string tag, input logic [31:0] inc, input logic mute,
                      input logic [1:0] sel, input int exp);
    nco_increment_value = inc;
    nco_mute            = mute;
    wave_sel            = sel;
    sample_tick         = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    check({tag, "_early"}, int'(sample_valid), 0);
    @(negedge clk);
    check({tag, "_valid"}, int'(sample_valid), 1);
    check(tag, int'(sample_data), exp);
  endtask

  int idx;
  int prev_s, cur_s, diff;

  initial begin
    rst = 1'b0;
    sample_tick = 1'b0;
    nco_increment_value = '0;
    nco_mute = 1'b1;
    wave_sel = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_data", int'(sample_data), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_active", int'(voice_active), 0);
    check("rst_acc", int'(dut.acc_q), 0);
    rst = 1'b1;
    @(negedge clk);

    // Muted ticks: silence, phase pinned at zero.
    for (int i = 0; i < 5; i++) begin
      tick("t1_mute", 32'h0800_0000, 1'b1, 2'd1, 0);
      check("t1_acc", int'(dut.acc_q), 0);
      check("t1_active", int'(voice_active), 0);
    end

    // Attack ramp on saw, gain n on tick n.
    for (int n = 1; n <= 32; n++) begin
      tick("t2_attack", 32'h0800_0000, 1'b0, 2'd1, exp_sample(1, n % 32, n));
      check("t2_active", int'(voice_active), 1);
    end
    check("t2_state", int'(dut.state_q), int'(SUSTAIN));
    check("t2_acc", int'(dut.acc_q), 0);

    // Sustain at full scale; phase wraps back to zero after 32 ticks.
    for (int n = 1; n <= 32; n++)
      tick("t3_wrap", 32'h0800_0000, 1'b0, 2'd1, exp_sample(1, n % 32, 32));
    check("t3_acc", int'(dut.acc_q), 0);

    // Aliased increment steps the index backwards.
    for (int j = 1; j <= 8; j++)
      tick("t3_down", 32'hF800_0000, 1'b0, 2'd1, exp_sample(1, 32 - j, 32));
    idx = 24;

    // Release on square: gain 31 down to 0, then IDLE with acc cleared.
    for (int j = 1; j <= 32; j++) begin
      idx = (idx + 1) % 32;
      if (j == 32) idx = 0;
      tick("t4_release", 32'h0800_0000, 1'b1, 2'd0, exp_sample(0, idx, 32 - j));
    end
    check("t4_state", int'(dut.state_q), int'(IDLE));
    check("t4_acc", int'(dut.acc_q), 0);
    check("t4_active", int'(voice_active), 0);
    check("t4_data", int'(sample_data), 0);

    // Zero increment holds phase; re-attack from release at gain 10.
    for (int g = 1; g <= 12; g++)
      tick("t5_up", 32'h0, 1'b0, 2'd0, exp_sample(0, 0, g));
    tick("t5_rel11", 32'h0, 1'b1, 2'd0, exp_sample(0, 0, 11));
    tick("t5_rel10", 32'h0, 1'b1, 2'd0, exp_sample(0, 0, 10));
    prev_s = int'(sample_data);
    tick("t5_reatk", 32'h0, 1'b0, 2'd0, exp_sample(0, 0, 11));
    cur_s = int'(sample_data);
    check("t5_state", int'(dut.state_q), int'(ATTACK));
    diff = (cur_s > prev_s) ? cur_s - prev_s : prev_s - cur_s;
    check("t5_step_ok", int'(diff <= 1024), 1);

    // Async reset mid-attack drops the in-flight sample.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int g = 1; g <= 7; g++)
      tick("t6_up", 32'h0800_0000, 1'b0, 2'd1, exp_sample(1, g, g));
    check("t6_state", int'(dut.state_q), int'(ATTACK));
    nco_increment_value = 32'h0800_0000;
    nco_mute = 1'b0;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_data", int'(sample_data), 0);
    check("t6_rst_valid", int'(sample_valid), 0);
    check("t6_rst_active", int'(voice_active), 0);
    @(negedge clk);
    check("t6_dropped", int'(sample_valid), 0);
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back ticks each yield their own valid.
    nco_increment_value = 32'h0800_0000;
    nco_mute = 1'b0;
    wave_sel = 2'd1;
    sample_tick = 1'b1;
    @(negedge clk);
    check("t7_early", int'(sample_valid), 0);
    @(negedge clk);
    sample_tick = 1'b0;
    check("t7_v1", int'(sample_valid), 1);
    check("t7_d1", int'(sample_data), exp_sample(1, 1, 1));
    @(negedge clk);
    check("t7_v2", int'(sample_valid), 1);
    check("t7_d2", int'(sample_data), exp_sample(1, 2, 2));
    @(negedge clk);
    check("t7_v_end", int'(sample_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
